// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer and its register file.
// Holds datapath widths, ALU opcode encodings, the sequencer state type,
// the registered response payload, and the carry-producing opcode lookup.
package alu_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned NREG   = 4;
  localparam int unsigned REG_AW = 2;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_AND  = 3'b010;
  localparam logic [OP_W-1:0] OP_OR   = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_NOTA = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b111;

  // Opcodes for which the ALU actually drives CarryOut.
  localparam int unsigned N_CARRY_OPS = 2;
  localparam logic [OP_W-1:0] CARRY_OPS [N_CARRY_OPS] = '{OP_ADD, OP_SUB};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Response payload held stable while rsp_valid is up.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              carry;
    logic              zero;
  } rsp_t;

  // True when CarryOut is meaningful for this opcode.
  function automatic logic op_has_carry(input logic [OP_W-1:0] op);
    op_has_carry = 1'b0;
    for (int unsigned i = 0; i < N_CARRY_OPS; i++) begin
      if (op == CARRY_OPS[i]) op_has_carry = 1'b1;
    end
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4-entry operand register file for the ALU command sequencer.
// One synchronous write port, two combinational read ports, synchronous
// active-low clear of every entry.
//   clk, rst_n        : clock, synchronous active-low clear
//   we, waddr, wdata  : write port
//   raddr_a / rdata_a : read port A
//   raddr_b / rdata_b : read port B
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];

  // Next-state of the storage array.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-side initiator for the external 4-bit combinational ALU.
// Accepts register-transfer commands on a valid/ready stream, reads operands
// from a local register file, drives registered A/B/opcode into the ALU,
// captures Result/CarryOut, writes the result back and returns it on a
// valid/ready response stream. Commands are fully serialized.
//   clk, rst_n                  : clock, synchronous active-low reset
//   cmd_valid / cmd_ready       : command handshake
//   cmd_op, cmd_load, cmd_imm_en, cmd_imm, cmd_rd, cmd_ra, cmd_rb : command
//   alu_a, alu_b, alu_op        : registered ALU operands/opcode
//   alu_result, alu_carry       : ALU outputs
//   rsp_valid / rsp_ready       : response handshake
//   rsp_data, rsp_carry, rsp_zero : response payload
module alu_cmd_sequencer
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic              cmd_load,
  input  logic              cmd_imm_en,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_ra,
  input  logic [REG_AW-1:0] cmd_rb,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              rsp_zero
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  rsp_t              rsp_q, rsp_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;

  // Read ports follow the offered command; they are only consumed on accept.
  alu_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (cmd_ra),
    .rdata_a (rf_rdata_a),
    .raddr_b (cmd_rb),
    .rdata_b (rf_rdata_b)
  );

  // Next-state, operand issue, write-back and response capture.
  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    rd_d     = rd_q;
    rsp_d    = rsp_q;
    rf_we    = 1'b0;
    rf_waddr = rd_q;
    rf_wdata = alu_result;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_load) begin
            // Loads bypass the ALU entirely and respond next cycle.
            rf_we       = 1'b1;
            rf_waddr    = cmd_rd;
            rf_wdata    = cmd_imm;
            rsp_d.data  = cmd_imm;
            rsp_d.carry = 1'b0;
            rsp_d.zero  = (cmd_imm == '0);
            state_d     = RESP;
          end else begin
            alu_a_d  = rf_rdata_a;
            alu_b_d  = cmd_imm_en ? cmd_imm : rf_rdata_b;
            alu_op_d = cmd_op;
            rd_d     = cmd_rd;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        // ALU has settled on the held operands; commit its result.
        rf_we       = 1'b1;
        rsp_d.data  = alu_result;
        // CarryOut is undriven for non-arithmetic opcodes, so mask it.
        rsp_d.carry = op_has_carry(alu_op_q) & alu_carry;
        rsp_d.zero  = (alu_result == '0);
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rd_q        <= '0;
      rsp_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      rsp_q       <= rsp_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_data  = rsp_q.data;
  assign rsp_carry = rsp_q.carry;
  assign rsp_zero  = rsp_q.zero;

endmodule
